// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/rvalid
// handshake to instruction memory and fills the IF/ID register, with redirect flush and stall skid.
module fetch_stage #(
    parameter int PC_W = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            stall,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            if_valid
);

    typedef enum logic [2:0] {
        START,
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } state_t;

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] pc_seq;
    logic            unused_brpc_bits;

    // Redirect targets are word-aligned and truncated to the PC width.
    function automatic logic [PC_W-1:0] align_target(input logic [31:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

    function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

    assign tgt              = align_target(BrPC);
    assign pc_seq           = next_seq_pc(pc_q);
    assign unused_brpc_bits = ^{BrPC[31:PC_W], BrPC[1:0]};

    assign imem_req  = (state_q == REQ);
    assign imem_addr = pc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= START;
            pc_q     <= '0;
            if_pc    <= '0;
            if_instr <= '0;
            if_valid <= 1'b0;
        end else begin
            if (!stall) begin
                if_valid <= 1'b0;
            end
            if (PcSel) begin
                // Redirect beats stall and rvalid; any in-flight response becomes stale.
                if_valid <= 1'b0;
                pc_q     <= tgt;
                case (state_q)
                    START:   state_q <= REQ;
                    REQ:     state_q <= DRAIN;
                    WAIT:    state_q <= imem_rvalid ? REQ : DRAIN;
                    HOLD:    state_q <= REQ;
                    DRAIN:   state_q <= imem_rvalid ? REQ : DRAIN;
                    default: state_q <= START;
                endcase
            end else begin
                case (state_q)
                    START: state_q <= REQ;
                    REQ:   state_q <= WAIT;
                    WAIT: begin
                        if (imem_rvalid) begin
                            if (!stall) begin
                                if_pc    <= pc_q;
                                if_instr <= imem_rdata;
                                if_valid <= 1'b1;
                                pc_q     <= pc_seq;
                                state_q  <= REQ;
                            end else begin
                                state_q  <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            if_pc    <= skid_pc;
                            if_instr <= skid_instr;
                            if_valid <= 1'b1;
                            pc_q     <= pc_seq;
                            state_q  <= REQ;
                        end
                    end
                    DRAIN: begin
                        if (imem_rvalid) begin
                            state_q <= REQ;
                        end
                    end
                    default: state_q <= START;
                endcase
            end
        end
    end

    // Skid contents are only meaningful in HOLD, so the data itself needs no reset.
    always_ff @(posedge clk) begin
        if (!PcSel && state_q == WAIT && imem_rvalid && stall) begin
            skid_pc    <= pc_q;
            skid_instr <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a latency-programmable memory model pushes expected
// fetches, a monitor pops them as they appear in IF/ID; directed checks cover reset, stall, redirect and wrap.
module tb_fetch_stage;

    localparam int PC_W = 9;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } item_t;

    logic            clk;
    logic            reset;
    logic            PcSel;
    logic [31:0]     BrPC;
    logic            stall;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic [PC_W-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            if_valid;

    item_t           exp_q[$];
    logic [PC_W-1:0] req_log[$];
    int              n_checks = 0;
    int              n_errors = 0;
    int              n_deliv  = 0;
    int              lat      = 1;
    int              cnt      = 0;
    logic            stale    = 1'b0;
    logic [PC_W-1:0] pend_addr;
    logic [PC_W-1:0] last_pc;

    fetch_stage #(.PC_W(PC_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .PcSel       (PcSel),
        .BrPC        (BrPC),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_valid    (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
        return (a == 9'h004) ? 32'h00500093 : {16'hC0DE, 7'h00, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_deliv(input int n, input string tag);
        int cyc;
        int target;
        cyc    = 0;
        target = n_deliv + n;
        while (n_deliv < target && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, n_deliv, target);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Memory model: one response per accepted request, `lat` cycles later; stale fetches are not expected.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            #2;
            imem_rvalid = 1'b0;
            if (!reset) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(pend_addr);
                        if (!stale) exp_q.push_back('{pc: pend_addr, instr: mem_word(pend_addr)});
                    end
                end
                if (imem_req) begin
                    pend_addr = imem_addr;
                    cnt       = lat;
                    stale     = 1'b0;
                    req_log.push_back(imem_addr);
                end
            end
        end
    end

    // Monitor: a redirect kills everything not yet in IF/ID; a new IF/ID load must match the queue head.
    initial begin
        logic st;
        logic ps;
        item_t e;
        forever begin
            @(posedge clk);
            st = stall;
            ps = PcSel;
            #1;
            if (!reset) begin
                exp_q.delete();
                stale = 1'b0;
            end else begin
                if (ps) begin
                    exp_q.delete();
                    stale = 1'b1;
                end
                if (if_valid && !st && !ps) begin
                    n_deliv++;
                    last_pc = if_pc;
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_pc", 32'(if_pc), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_pc", 32'(if_pc), 32'(e.pc));
                        chk("sb_instr", if_instr, e.instr);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        PcSel = 1'b0;
        BrPC  = '0;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req",      32'(imem_req),  32'h0);
        chk("rst_addr",     32'(imem_addr), 32'h0);
        chk("rst_if_pc",    32'(if_pc),     32'h0);
        chk("rst_if_instr", if_instr,       32'h0);
        chk("rst_if_valid", 32'(if_valid),  32'h0);
        reset = 1'b1;
        #1;
        chk("start_req", 32'(imem_req), 32'h0);

        wait_deliv(3, "seq_deliv");
        chk("seq_addr0", 32'(req_log[0]), 32'h000);
        chk("seq_addr1", 32'(req_log[1]), 32'h004);
        chk("seq_addr2", 32'(req_log[2]), 32'h008);

        // Stall while the PC 0x004 response lands
        do_reset();
        wait_deliv(1, "stall_first");
        stall = 1'b1;
        repeat (3) @(negedge clk);
        chk("hold_req",      32'(imem_req), 32'h0);
        chk("hold_if_pc",    32'(if_pc),    32'h000);
        chk("hold_if_valid", 32'(if_valid), 32'h1);
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("unstall_pc",    32'(if_pc),    32'h004);
        chk("unstall_instr", if_instr,      32'h00500093);
        chk("unstall_valid", 32'(if_valid), 32'h1);

        // Redirect in WAIT with a slow response
        lat = 3;
        @(negedge clk);
        @(negedge clk);
        PcSel = 1'b1;
        BrPC  = 32'h0000_0040;
        @(negedge clk);
        PcSel = 1'b0;
        chk("redir_valid", 32'(if_valid),  32'h0);
        chk("redir_addr",  32'(imem_addr), 32'h040);
        chk("redir_req",   32'(imem_req),  32'h0);
        lat = 1;
        wait_deliv(1, "redir_deliv");
        chk("redir_first_pc", 32'(last_pc), 32'h040);

        // Redirect together with stall
        stall = 1'b1;
        PcSel = 1'b1;
        BrPC  = 32'h0000_0100;
        @(negedge clk);
        PcSel = 1'b0;
        stall = 1'b0;
        chk("flush_stall_valid", 32'(if_valid),  32'h0);
        chk("flush_stall_addr",  32'(imem_addr), 32'h100);
        wait_deliv(1, "flush_deliv");
        chk("flush_first_pc", 32'(last_pc), 32'h100);

        // Truncated, aligned target and PC wrap
        PcSel = 1'b1;
        BrPC  = 32'h0000_03FE;
        @(negedge clk);
        PcSel = 1'b0;
        chk("wrap_tgt_addr", 32'(imem_addr), 32'h1FC);
        wait_deliv(1, "wrap_deliv0");
        chk("wrap_pc0",  32'(last_pc),   32'h1FC);
        chk("wrap_addr", 32'(imem_addr), 32'h000);
        lat = 3;
        wait_deliv(1, "wrap_deliv1");
        chk("wrap_pc1", 32'(last_pc), 32'h000);
        wait_deliv(1, "wrap_deliv2");
        chk("wrap_pc2", 32'(last_pc), 32'h004);

        // Reset asserted while draining a stale response
        PcSel = 1'b1;
        BrPC  = 32'h0000_0080;
        @(negedge clk);
        PcSel = 1'b0;
        chk("drain_addr", 32'(imem_addr), 32'h080);
        reset = 1'b0;
        #1;
        chk("midrst_req",      32'(imem_req),  32'h0);
        chk("midrst_addr",     32'(imem_addr), 32'h0);
        chk("midrst_if_pc",    32'(if_pc),     32'h0);
        chk("midrst_if_instr", if_instr,       32'h0);
        chk("midrst_if_valid", 32'(if_valid),  32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("restart_req", 32'(imem_req), 32'h0);
        wait_deliv(1, "restart_deliv");
        chk("restart_pc", 32'(last_pc), 32'h000);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RV32 core.
- Holds the program counter and issues one request at a time to instruction memory over a req/rvalid handshake.
- Presents fetched instructions to decode through the IF/ID register.
- Consumes the redirect produced by the execute-stage branch logic (PcSel, BrPC) and flushes wrong-path fetches. Honours stalls from the hazard unit.

Parameters:
- PC_W, 9, width of the PC and of the instruction-memory byte address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- PcSel  in  1  redirect request from execute; 1 = take BrPC.
- BrPC  in  32  redirect target byte address.
- stall  in  1  hazard unit; 1 = decode cannot accept, IF/ID holds.
- imem_req  out  1  request strobe; accepted in the cycle it is high.
- imem_addr  out  PC_W  request byte address; equals the PC register.
- imem_rvalid  in  1  response valid; exactly one per accepted request, 1 or more cycles later, never in the request cycle.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- if_pc  out  PC_W  IF/ID: PC of the held instruction.
- if_instr  out  32  IF/ID: instruction word.
- if_valid  out  1  IF/ID: 1 = if_instr is a real instruction, 0 = bubble.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc_q=0, state=START.
  - if_pc=0, if_instr=0, if_valid=0, skid buffer empty.
  - imem_req=0.
- imem_req=1 only in state REQ. imem_addr=pc_q at all times.
- Aligned redirect target: tgt = {BrPC[PC_W-1:2],2'b00}. Upper BrPC bits are dropped, low 2 bits forced to 0.
- Sequential PC: pc_q+4, wrapping modulo 2^PC_W (e.g. 9'h1FC -> 9'h000).
- FSM without redirect:
  - START -> REQ unconditionally, one cycle after reset release.
  - REQ -> WAIT.
  - WAIT, no rvalid: stay in WAIT.
  - WAIT, rvalid and stall=0: IF/ID <= {pc_q, imem_rdata, valid=1}; pc_q <= pc_q+4; -> REQ.
  - WAIT, rvalid and stall=1: skid <= {pc_q, imem_rdata}; -> HOLD.
  - HOLD, stall=1: stay in HOLD, IF/ID unchanged.
  - HOLD, stall=0: IF/ID <= {skid, valid=1}; pc_q <= pc_q+4; -> REQ.
  - DRAIN, no rvalid: stay in DRAIN.
  - DRAIN, rvalid: discard the data; -> REQ.
- IF/ID update rule, no redirect:
  - stall=1: all if_* hold.
  - stall=0 and no instruction loaded this cycle: if_valid <= 0 (bubble); if_pc and if_instr hold.
- Redirect (PcSel=1) has highest priority over stall and rvalid, in any state except START:
  - if_valid <= 0 (flush beats stall); pc_q <= tgt; skid emptied.
  - From REQ: the request at the old PC is already issued -> DRAIN.
  - From WAIT with rvalid=0: -> DRAIN.
  - From WAIT with rvalid=1: data discarded -> REQ.
  - From HOLD: skid discarded -> REQ.
  - From DRAIN with rvalid=0: pc_q <= tgt, stay in DRAIN.
  - From DRAIN with rvalid=1: data discarded -> REQ.
- Redirect during START: pc_q <= tgt, -> REQ.
- No instruction fetched from a stale PC ever reaches if_valid=1.
- At most one outstanding request; max throughput is one instruction per 2 cycles (REQ, WAIT with next-cycle rvalid).
- Reset asserted mid-operation: immediate return to reset values. Any in-flight memory response after release is not issued by this block; memory is reset by the same signal.

Test Plan:
- Reset, then 1-cycle memory latency, stall=0: imem_addr sequence 0x000, 0x004, 0x008. if_valid pulses with if_pc 0x000, 0x004, 0x008 and matching if_instr. imem_req=0 while reset=0 and in the first cycle after release.
- stall=1 for 3 cycles while rvalid returns PC 0x004 data 0x00500093: state HOLD, if_* unchanged. On stall=0, if_pc=0x004, if_instr=0x00500093, if_valid=1 in the next cycle.
- PcSel=1 with BrPC=0x00000040 in a WAIT cycle, response arrives 2 cycles later: response discarded, if_valid=0. Next imem_addr=0x040 and the first valid if_pc=0x040.
- PcSel=1 with stall=1 simultaneously: if_valid=0 next cycle; pc_q=tgt.
- BrPC=0x000003FE with PC_W=9: next request address 0x1FC. After fetching it, the following request is 0x000 (wrap).
- Assert reset while in DRAIN: all outputs return to reset values immediately. Fetch restarts at 0x000.
